dm_run_ctrl: RTL and testbench

- Run sequencer for the single data-memory port of the processor core.
- Owns the memory port while it bulk-loads an operand block (pattern-search string plus pattern byte). It then pulses the core's start request and waits for the core's done, handing the port to the core during that interval.
- Afterwards it reclaims the port and streams the result bytes (counts at addresses 33..35) out over a valid/ready interface.
- Replaces testbench backdoor memory writes with a synthesizable load/run/readback path.

---
 rtl/dm_run_ctrl_pkg.sv | 29 ++
 rtl/dm_run_ctrl_if.sv | 45 ++++
 rtl/dm_run_ctrl_port_mux.sv | 25 ++
 rtl/dm_run_ctrl.sv | 133 +++++++++++++
 tb/tb_dm_run_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_run_ctrl_pkg.sv
// Shared definitions for the data-memory run sequencer.
// - state_t   : sequencer states
// - P3_*      : program-3 memory map (operand string, pattern byte, results)
// - cnt_w()   : counter width able to hold 0..n-1
package dm_run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_READ,
        S_FIN
    } state_t;

    localparam int DW          = 8;   // memory data width
    localparam int IDX_W       = 3;   // result index width (RES_LEN <= 8)

    localparam int P3_STR_BASE = 0;
    localparam int P3_STR_LEN  = 32;
    localparam int P3_PAT_ADDR = 32;
    localparam int P3_RES_BASE = 33;
    localparam int P3_RES_LEN  = 3;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dm_run_ctrl_if.sv
// Bus bundle between the run sequencer and its surroundings.
// - load_*  : operand byte stream into the sequencer
// - core_*  : core start/done and the core's memory driver
// - dm_*    : the single data-memory port (rdata combinational from addr)
// - res_*   : result byte stream out of the sequencer
// slave = sequencer view, master = environment view.
interface dm_run_ctrl_if
    import dm_run_ctrl_pkg::*;
#(
    parameter int AW = 8
);
    logic             load_valid;
    logic [DW-1:0]    load_data;
    logic             load_ready;

    logic             core_start;
    logic             core_done;
    logic [AW-1:0]    core_addr;
    logic [DW-1:0]    core_wdata;
    logic             core_we;

    logic [AW-1:0]    dm_addr;
    logic [DW-1:0]    dm_wdata;
    logic             dm_we;
    logic [DW-1:0]    dm_rdata;

    logic             res_valid;
    logic [DW-1:0]    res_data;
    logic [IDX_W-1:0] res_idx;
    logic             res_ready;

    modport slave (
        input  load_valid, load_data, core_done, core_addr, core_wdata, core_we,
               dm_rdata, res_ready,
        output load_ready, core_start, dm_addr, dm_wdata, dm_we,
               res_valid, res_data, res_idx
    );

    modport master (
        output load_valid, load_data, core_done, core_addr, core_wdata, core_we,
               dm_rdata, res_ready,
        input  load_ready, core_start, dm_addr, dm_wdata, dm_we,
               res_valid, res_data, res_idx
    );
endinterface

// File: rtl/dm_run_ctrl_port_mux.sv
// Combinational owner select for the data-memory port.
// - core_sel  : 1 = core drives the port, 0 = sequencer drives it
// - ctrl_*    : sequencer address / write data / write enable
// - core_*    : core address / write data / write enable
// - dm_*      : muxed port outputs
module dm_port_mux
    import dm_run_ctrl_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          core_sel,
    input  logic [AW-1:0] ctrl_addr,
    input  logic [DW-1:0] ctrl_wdata,
    input  logic          ctrl_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    input  logic          core_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    output logic          dm_we
);
    assign dm_addr  = core_sel ? core_addr  : ctrl_addr;
    assign dm_wdata = core_sel ? core_wdata : ctrl_wdata;
    assign dm_we    = core_sel ? core_we    : ctrl_we;
endmodule

// File: rtl/dm_run_ctrl.sv
// Load/run/readback sequencer for the core's single data-memory port.
// - clk, reset (async, active low)
// - go          : start a sequence (sampled in IDLE only)
// - busy        : high outside IDLE
// - run_done    : one-cycle pulse in FIN
// - timeout_err : sticky RUN-timeout flag, cleared by the next accepted go
// - bus         : load stream, core handshake/port, memory port, result stream
module dm_run_ctrl
    import dm_run_ctrl_pkg::*;
#(
    parameter int AW        = 8,
    parameter int LOAD_BASE = P3_STR_BASE,
    parameter int LOAD_LEN  = P3_STR_LEN + 1,
    parameter int RES_BASE  = P3_RES_BASE,
    parameter int RES_LEN   = P3_RES_LEN,
    parameter int TIMEOUT   = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    output logic         busy,
    output logic         run_done,
    output logic         timeout_err,
    dm_run_ctrl_if.slave bus
);
    localparam int LCW = cnt_w(LOAD_LEN);
    localparam int TW  = cnt_w(TIMEOUT);
    localparam logic [LCW-1:0]   LOAD_LAST = LCW'(LOAD_LEN - 1);
    localparam logic [IDX_W-1:0] RES_LAST  = IDX_W'(RES_LEN - 1);
    localparam logic [TW-1:0]    TO_LAST   = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           state, state_nx;
    logic [LCW-1:0]   lcnt;
    logic [IDX_W-1:0] idx;
    logic [TW-1:0]    tcnt;
    logic             armed;
    logic             core_sel;
    logic             to_hit;

    logic [AW-1:0]    ctrl_addr;
    logic [DW-1:0]    ctrl_wdata;
    logic             ctrl_we;
    logic [AW-1:0]    dm_addr;
    logic [DW-1:0]    dm_wdata;
    logic             dm_we;

    assign to_hit = (TIMEOUT != 0) && (tcnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (go) state_nx = S_LOAD;
            S_LOAD:  if (bus.load_valid && lcnt == LOAD_LAST) state_nx = S_START;
            S_START: state_nx = S_RUN;
            // done only counts once it has been seen low during this run
            S_RUN:   if (bus.core_done && armed) state_nx = S_READ;
                     else if (to_hit)            state_nx = S_FIN;
            S_READ:  if (bus.res_ready && idx == RES_LAST) state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Counters, arming, error flag and the registered port owner.
    // The core owns the port in every state except LOAD and READ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lcnt        <= '0;
            idx         <= '0;
            tcnt        <= '0;
            armed       <= 1'b0;
            timeout_err <= 1'b0;
            core_sel    <= 1'b1;
        end else begin
            core_sel <= !(state_nx == S_LOAD || state_nx == S_READ);
            unique case (state)
                S_IDLE:  if (go) begin
                             lcnt        <= '0;
                             timeout_err <= 1'b0;
                         end
                S_LOAD:  if (bus.load_valid) lcnt <= lcnt + 1'b1;
                S_START: begin
                             armed <= 1'b0;
                             tcnt  <= '0;
                             idx   <= '0;
                         end
                S_RUN:   begin
                             if (!bus.core_done) armed <= 1'b1;
                             tcnt <= tcnt + 1'b1;
                             if (state_nx == S_FIN) timeout_err <= 1'b1;
                         end
                S_READ:  if (bus.res_ready) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    assign ctrl_addr  = (state == S_READ) ? AW'(RES_BASE) + AW'(idx)
                                          : AW'(LOAD_BASE) + AW'(lcnt);
    assign ctrl_wdata = bus.load_data;
    assign ctrl_we    = (state == S_LOAD) && bus.load_valid;

    dm_port_mux #(.AW(AW)) u_mux (
        .core_sel   (core_sel),
        .ctrl_addr  (ctrl_addr),
        .ctrl_wdata (ctrl_wdata),
        .ctrl_we    (ctrl_we),
        .core_addr  (bus.core_addr),
        .core_wdata (bus.core_wdata),
        .core_we    (bus.core_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_we      (dm_we)
    );

    assign bus.dm_addr    = dm_addr;
    assign bus.dm_wdata   = dm_wdata;
    assign bus.dm_we      = dm_we;

    assign busy           = (state != S_IDLE);
    assign run_done       = (state == S_FIN);
    assign bus.load_ready = (state == S_LOAD);
    assign bus.core_start = (state == S_START);
    assign bus.res_valid  = (state == S_READ);
    // address is held while stalled and nothing writes, so rdata stays put
    assign bus.res_data   = (state == S_READ) ? bus.dm_rdata : '0;
    assign bus.res_idx    = (state == S_READ) ? idx : '0;
endmodule

// File: tb/tb_dm_run_ctrl.sv
module tb_dm_run_ctrl;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic go = 1'b0;
    logic busy, run_done, timeout_err;

    dm_run_ctrl_if #(.AW(AW)) bif ();

    dm_run_ctrl #(
        .AW(AW), .LOAD_BASE(0), .LOAD_LEN(33), .RES_BASE(33), .RES_LEN(3), .TIMEOUT(100)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .busy(busy),
        .run_done(run_done), .timeout_err(timeout_err), .bus(bif)
    );

    always #5 clk = ~clk;

    // memory model: combinational read, write on posedge
    logic [7:0] mem [256];
    assign bif.dm_rdata = mem[bif.dm_addr];

    bit mem_init = 1'b0;
    int wr_cnt [256];
    int wr_total, start_w, start_max, start_pulses, done_pulses, rv_cycles;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
            mem_init <= 1'b1;
        end
        if (bif.dm_we) mem[bif.dm_addr] <= bif.dm_wdata;
        if (bif.dm_we && !bif.core_we) begin
            wr_cnt[bif.dm_addr] <= wr_cnt[bif.dm_addr] + 1;
            wr_total <= wr_total + 1;
        end
        if (bif.core_start) start_w <= start_w + 1;
        else begin
            start_w <= 0;
            if (start_w > 0) begin
                start_pulses <= start_pulses + 1;
                if (start_w > start_max) start_max <= start_w;
            end
        end
        if (run_done)      done_pulses <= done_pulses + 1;
        if (bif.res_valid) rv_cycles   <= rv_cycles + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic go_pulse();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic load_run(input logic [7:0] b, input bit gap, input int n);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                bif.load_valid = 1'b0;
                @(negedge clk);
            end
            bif.load_valid = 1'b1;
            bif.load_data  = b;
            @(negedge clk);
        end
        bif.load_valid = 1'b0;
    endtask

    // call on the first RUN negedge; seen = RUN cycle at which READ or FIN shows
    task automatic core_run(input int drop_at, input int rise_at, input bit wr,
                            input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, output int seen);
        seen = -1;
        for (int c = 0; c < 300; c++) begin
            if (bif.res_valid || run_done) begin
                seen = c;
                break;
            end
            if (c >= rise_at)      bif.core_done = 1'b1;
            else if (c >= drop_at) bif.core_done = 1'b0;
            bif.core_we    = wr && c >= 1 && c <= 3;
            bif.core_addr  = 8'(32 + c);
            bif.core_wdata = (c == 1) ? r0 : (c == 2) ? r1 : r2;
            @(negedge clk);
        end
        bif.core_we = 1'b0;
    endtask

    task automatic read_res(input int stall, input logic [7:0] e0,
                            input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] e [3];
        int unstable;
        e = '{e0, e1, e2};
        for (int k = 0; k < 3; k++) begin
            unstable = 0;
            for (int s = 0; s < stall; s++) begin
                bif.res_ready = 1'b0;
                if (!bif.res_valid || bif.res_data !== e[k]) unstable++;
                @(negedge clk);
            end
            if (stall > 0) chk($sformatf("stall_stable%0d", k), unstable, 0);
            bif.res_ready = 1'b1;
            chk($sformatf("res_valid%0d", k), bif.res_valid, 1);
            chk($sformatf("res_data%0d", k), bif.res_data, e[k]);
            chk($sformatf("res_idx%0d", k), bif.res_idx, k);
            @(negedge clk);
        end
        bif.res_ready = 1'b0;
        chk("fin_pulse", run_done, 1);
        @(negedge clk);
        chk("fin_one_cycle", run_done, 0);
        chk("back_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen, w0, d0, s0, rv0, nz, badc;
        int base [256];

        bif.load_valid = 1'b0; bif.load_data  = 8'h00;
        bif.core_done  = 1'b0; bif.core_addr  = 8'h5A;
        bif.core_wdata = 8'h00; bif.core_we   = 1'b0;
        bif.res_ready  = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_load_ready", bif.load_ready, 0);
        chk("rst_core_start", bif.core_start, 0);
        chk("rst_res_valid", bif.res_valid, 0);
        chk("rst_run_done", run_done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_dm_addr_pass", bif.dm_addr, 8'h5A);
        reset = 1'b1;
        @(negedge clk);

        // load_valid outside LOAD: no write
        w0 = wr_total;
        bif.load_valid = 1'b1; bif.load_data = 8'h99;
        repeat (3) @(negedge clk);
        bif.load_valid = 1'b0;
        chk("stray_load_writes", wr_total - w0, 0);
        chk("stray_load_busy", busy, 0);

        // test 1: zeros, core writes results, done after 50 cycles
        w0 = wr_total; d0 = done_pulses;
        go_pulse();
        chk("t1_busy", busy, 1);
        chk("t1_load_ready", bif.load_ready, 1);
        load_run(8'h00, 1'b0, 33);
        chk("t1_start", bif.core_start, 1);
        @(negedge clk);
        core_run(0, 50, 1'b1, 8'hA0, 8'h20, 8'hFC, seen);
        chk("t1_read_cycle", seen, 51);
        read_res(0, 8'hA0, 8'h20, 8'hFC);
        nz = 0;
        for (int i = 0; i < 33; i++) if (mem[i] !== 8'h00) nz++;
        chk("t1_mem_zero", nz, 0);
        chk("t1_load_writes", wr_total - w0, 33);
        chk("t1_run_done_cnt", done_pulses - d0, 1);

        // test 2: gapped load of 0x55
        for (int a = 0; a < 256; a++) base[a] = wr_cnt[a];
        s0 = start_pulses;
        go_pulse();
        load_run(8'h55, 1'b1, 33);
        chk("t2_start", bif.core_start, 1);
        @(negedge clk);
        chk("t2_start_gone", bif.core_start, 0);
        core_run(0, 10, 1'b1, 8'h11, 8'h22, 8'h33, seen);
        chk("t2_read_cycle", seen, 11);
        read_res(0, 8'h11, 8'h22, 8'h33);
        badc = 0;
        for (int a = 0; a < 256; a++)
            if (wr_cnt[a] - base[a] != ((a < 33) ? 1 : 0)) badc++;
        chk("t2_write_map", badc, 0);
        nz = 0;
        for (int i = 0; i < 33; i++) if (mem[i] !== 8'h55) nz++;
        chk("t2_mem_55", nz, 0);
        chk("t2_start_width", start_max, 1);
        chk("t2_start_pulses", start_pulses - s0, 1);

        // test 3: stale done, low at 5, high at 20; stalled readback
        d0 = done_pulses;
        go_pulse();
        load_run(8'h00, 1'b0, 33);
        chk("t3_start", bif.core_start, 1);
        @(negedge clk);
        core_run(5, 20, 1'b1, 8'h31, 8'h32, 8'h33, seen);
        chk("t3_read_cycle", seen, 21);
        read_res(10, 8'h31, 8'h32, 8'h33);
        chk("t3_run_done_cnt", done_pulses - d0, 1);

        // test 4: core never finishes
        rv0 = rv_cycles;
        go_pulse();
        load_run(8'h00, 1'b0, 33);
        chk("t4_start", bif.core_start, 1);
        @(negedge clk);
        core_run(0, 1000, 1'b0, 8'h00, 8'h00, 8'h00, seen);
        chk("t4_fin_cycle", seen, 100);
        chk("t4_fin_pulse", run_done, 1);
        chk("t4_timeout_err", timeout_err, 1);
        @(negedge clk);
        chk("t4_idle", busy, 0);
        chk("t4_err_sticky", timeout_err, 1);
        chk("t4_no_res_valid", rv_cycles - rv0, 0);

        // test 5: next go clears the error; reset mid-LOAD after 10 bytes
        go_pulse();
        chk("t5_err_cleared", timeout_err, 0);
        load_run(8'h11, 1'b0, 10);
        reset = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_load_ready", bif.load_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        d0 = done_pulses;
        for (int a = 0; a < 256; a++) base[a] = wr_cnt[a];
        go_pulse();
        load_run(8'h77, 1'b0, 33);
        chk("t5_start", bif.core_start, 1);
        badc = 0;
        for (int a = 0; a < 256; a++)
            if (wr_cnt[a] - base[a] != ((a < 33) ? 1 : 0)) badc++;
        chk("t5_reload_map", badc, 0);
        @(negedge clk);
        core_run(0, 5, 1'b1, 8'h01, 8'h02, 8'h03, seen);
        chk("t5_read_cycle", seen, 6);
        read_res(0, 8'h01, 8'h02, 8'h03);
        chk("t5_run_done_cnt", done_pulses - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
